// File: rtl/prince_inv_affine_serial.sv
// Nibble-serial inverse-direction affine layer for a 3-share PRINCE state.
// Each share rotates through its own map instance; out_valid follows a one-cycle settle after the last rotation.
module prince_inv_affine_serial #(
  parameter int          WIDTH = 64,
  parameter int          LANES = 1,
  parameter logic [15:0] MAT   = 16'h8C23,
  parameter logic [3:0]  CST   = 4'h5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3
);

  localparam int STEP = 4 * LANES;
  localparam int N    = WIDTH / STEP;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             armed;
  logic [WIDTH-1:0] r1, r2, r3;

  function automatic logic [3:0] amap(input logic [3:0] x);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) y[i] = ^(MAT[4*i +: 4] & x);
    return y ^ CST;
  endfunction

  // Low LANES nibbles are mapped and re-enter at the top; only one share per call.
  function automatic logic [WIDTH-1:0] step_share(input logic [WIDTH-1:0] r);
    logic [STEP-1:0] mapped;
    for (int l = 0; l < LANES; l++) mapped[4*l +: 4] = amap(r[4*l +: 4]);
    return (r >> STEP) | (WIDTH'(mapped) << (WIDTH - STEP));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      armed     <= 1'b0;
      out_valid <= 1'b0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r1    <= x1;
            r2    <= x2;
            r3    <= x3;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          r1 <= step_share(r1);
          r2 <= step_share(r2);
          r3 <= step_share(r3);
          if (cnt == LAST) state <= DONE;
          else             cnt   <= cnt + 1'b1;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // armed keeps in_ready low through reset and until the first edge after release.
  assign in_ready = armed && (state == IDLE);
  assign y1 = r1;
  assign y2 = r2;
  assign y3 = r3;

endmodule

// File: tb/tb_prince_inv_affine_serial.sv
// Bench for prince_inv_affine_serial: LANES=1 and LANES=4 instances, table vectors,
// scoreboard-checked random traffic, latency, hold, abort-by-reset and single-accept sequences.
module tb_prince_inv_affine_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv1, ir1, ov1, or1;
  logic [63:0] a1, a2, a3, b1, b2, b3;
  logic        iv4, ir4, ov4, or4;
  logic [63:0] c1, c2, c3, d1, d2, d3;

  prince_inv_affine_serial #(.WIDTH(64), .LANES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .x1(a1), .x2(a2), .x3(a3),
    .out_valid(ov1), .out_ready(or1), .y1(b1), .y2(b2), .y3(b3)
  );

  prince_inv_affine_serial #(.WIDTH(64), .LANES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .x1(c1), .x2(c2), .x3(c3),
    .out_valid(ov4), .out_ready(or4), .y1(d1), .y2(d2), .y3(d3)
  );

  typedef struct {
    logic [63:0] x1, x2, x3, e1, e2, e3;
  } vec_t;

  typedef struct {
    logic [63:0] e1, e2, e3, es;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  bit   stall_en = 1'b0;
  int   acc4 = 0;

  // Nibble map written out bitwise: y0=x0^x1^1, y1=x1, y2=x2^x3^1, y3=x3.
  function automatic logic [63:0] amodel(input logic [63:0] x);
    logic [63:0] y;
    logic [3:0]  n;
    for (int i = 0; i < 16; i++) begin
      n = x[4*i +: 4];
      y[4*i +: 4] = {n[3], n[2] ^ n[3] ^ 1'b1, n[1], n[0] ^ n[1] ^ 1'b1};
    end
    return y;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Output-side scoreboard for the LANES=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov1 && or1) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected actual=out_valid expected=no_output");
      end else begin
        e = sbq.pop_front();
        chk("sb_y1", b1, e.e1);
        chk("sb_y2", b2, e.e2);
        chk("sb_y3", b3, e.e3);
        chk("sb_sum", b1 ^ b2 ^ b3, e.es);
      end
    end
  end

  always @(posedge clk) begin
    if (stall_en) begin
      #1;
      or1 = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) if (!rst && iv4 && ir4) acc4++;

  task automatic push_exp(input logic [63:0] x1, input logic [63:0] x2, input logic [63:0] x3);
    exp_t e;
    e.e1 = amodel(x1);
    e.e2 = amodel(x2);
    e.e3 = amodel(x3);
    e.es = amodel(x1 ^ x2 ^ x3);
    sbq.push_back(e);
  endtask

  task automatic send1(input logic [63:0] x1, input logic [63:0] x2, input logic [63:0] x3);
    int n = 0;
    iv1 = 1'b1; a1 = x1; a2 = x2; a3 = x3;
    @(negedge clk);
    while (!ir1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail_now("send1_accept");
    else push_exp(x1, x2, x3);
    @(posedge clk);
    #1;
    iv1 = 1'b0;
  endtask

  task automatic drain1();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) fail_now("drain1");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[3];
    logic [63:0] hold, r1v, r2v, r3v;
    int k, seen, n;

    tbl[0] = '{64'h000000000000000F, 64'h0, 64'h0,
               64'h555555555555555F, 64'h5555555555555555, 64'h5555555555555555};
    tbl[1] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0,
               64'h5467102398ABDCEF, 64'hFECDBA8932017645, 64'h5555555555555555};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0,
               64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h5555555555555555};

    rst = 1'b1;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; a2 = '0; a3 = '0;
    iv4 = 1'b0; or4 = 1'b0; c1 = '0; c2 = '0; c3 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(ov1), 64'd0);
    chk("rst_in_ready", 64'(ir1), 64'd0);
    chk("rst_y1", b1, 64'd0);
    chk("rst_y2", b2, 64'd0);
    chk("rst_y3", b3, 64'd0);
    chk("rst_in_ready4", 64'(ir4), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 64'(ir1), 64'd1);

    // Table vectors: direct check of the expected outputs from the table
    or1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send1(tbl[i].x1, tbl[i].x2, tbl[i].x3);
      n = 0;
      while (!(ov1 && or1) && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 100) fail_now("tbl_out");
      chk("tbl_y1", b1, tbl[i].e1);
      chk("tbl_y2", b2, tbl[i].e2);
      chk("tbl_y3", b3, tbl[i].e3);
      drain1();
    end

    // Latency and hold with LANES=1
    or1 = 1'b0;
    iv1 = 1'b1; a1 = tbl[1].x1; a2 = tbl[1].x2; a3 = tbl[1].x3;
    n = 0;
    while (!ir1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    push_exp(a1, a2, a3);
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    k = 0;
    while (!ov1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("lat_l1_edges", 64'(k), 64'd17);
    hold = b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_y1", b1, hold);
      chk("hold_in_ready", 64'(ir1), 64'd0);
      chk("hold_out_valid", 64'(ov1), 64'd1);
    end
    @(posedge clk);
    #1;
    or1 = 1'b1;
    @(posedge clk);
    #1;
    or1 = 1'b0;
    chk("post_hs_in_ready", 64'(ir1), 64'd1);
    chk("post_hs_out_valid", 64'(ov1), 64'd0);

    // Random traffic with stalls
    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r1v = {$urandom, $urandom};
      r2v = {$urandom, $urandom};
      r3v = {$urandom, $urandom};
      send1(r1v, r2v, r3v);
    end
    drain1();
    stall_en = 1'b0;
    @(posedge clk);
    #2;
    or1 = 1'b1;

    // Abort in BUSY at counter 7
    iv1 = 1'b1; a1 = {$urandom, $urandom}; a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
    n = 0;
    while (!ir1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_y1", b1, 64'd0);
    chk("abort_out_valid", 64'(ov1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov1) seen++;
    end
    chk("abort_no_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send1(tbl[1].x1, tbl[1].x2, tbl[1].x3);
    drain1();

    // LANES=4: latency and exactly one accept while in_valid stays high
    acc4 = 0;
    iv4 = 1'b1; c1 = tbl[1].x1; c2 = tbl[1].x2; c3 = tbl[1].x3;
    n = 0;
    while (!ir4 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    k = 0;
    while (!ov4 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("lat_l4_edges", 64'(k), 64'd5);
    chk("l4_y1", d1, tbl[1].e1);
    chk("l4_y2", d2, tbl[1].e2);
    chk("l4_y3", d3, tbl[1].e3);
    repeat (3) @(posedge clk);
    #1;
    chk("l4_hold_y1", d1, tbl[1].e1);
    or4 = 1'b1;
    @(posedge clk);
    #1;
    or4 = 1'b0;
    iv4 = 1'b0;
    @(negedge clk);
    chk("l4_accepts", 64'(acc4), 64'd1);
    chk("l4_in_ready", 64'(ir4), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
